// File: rtl/pong_pkg.sv
// Shared constants for the pong game blocks: FSM state encoding and game defaults.
package pong_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    SERVE_WAIT,
    PLAY,
    OVER
  } state_t;

  localparam int WIN_SCORE_DEF = 7;
  localparam int SCORE_W_DEF   = 4;

endpackage

// File: rtl/score_counter.sv
// Saturating score counter with synchronous clear and increment.
// `hit` flags that the current increment lands exactly on the limit.
module score_counter #(
  parameter int W     = 4,
  parameter int LIMIT = 7
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt,
  output logic         hit
);

  localparam logic [W-1:0] LIM    = W'(LIMIT);
  localparam logic [W-1:0] LIM_M1 = W'(LIMIT - 1);

  logic full;

  assign full = (cnt == LIM);
  assign hit  = inc && (cnt == LIM_M1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)            cnt <= '0;
    else if (clr)          cnt <= '0;
    else if (inc && !full) cnt <= cnt + W'(1);
  end

endmodule

// File: rtl/serve_ctrl.sv
// Pong serve/score controller: sequences arm -> serve wait -> play, keeps the
// score, and declares a winner once either side reaches WIN_SCORE.
module serve_ctrl
  import pong_pkg::*;
#(
  parameter int WIN_SCORE = WIN_SCORE_DEF,
  parameter int SCORE_W   = SCORE_W_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               btn_start,
  input  logic               miss_l,
  input  logic               miss_r,
  input  logic               timer_up,
  output logic               timer_start,
  output logic               ball_reset,
  output logic               ball_en,
  output logic               serve_dir,
  output logic [SCORE_W-1:0] score_l,
  output logic [SCORE_W-1:0] score_r,
  output logic               game_over,
  output logic               winner
);

  state_t state, nxt;
  logic   clr, inc_l, inc_r, hit_l, hit_r;
  logic   only_l, only_r;

  assign only_l = miss_l && !miss_r;
  assign only_r = miss_r && !miss_l;

  score_counter #(.W(SCORE_W), .LIMIT(WIN_SCORE)) u_score_l (
    .clk(clk), .rst_n(rst_n), .clr(clr), .inc(inc_l), .cnt(score_l), .hit(hit_l)
  );

  score_counter #(.W(SCORE_W), .LIMIT(WIN_SCORE)) u_score_r (
    .clk(clk), .rst_n(rst_n), .clr(clr), .inc(inc_r), .cnt(score_r), .hit(hit_r)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nxt;
  end

  // timer_up is only looked at from SERVE_WAIT; in ARM it may still be stale.
  always_comb begin
    nxt   = state;
    clr   = 1'b0;
    inc_l = 1'b0;
    inc_r = 1'b0;
    case (state)
      IDLE: if (btn_start) begin
        clr = 1'b1;
        nxt = ARM;
      end
      ARM:        nxt = SERVE_WAIT;
      SERVE_WAIT: if (timer_up) nxt = PLAY;
      PLAY: begin
        if (only_l) begin
          inc_r = 1'b1;
          nxt   = hit_r ? OVER : ARM;
        end else if (only_r) begin
          inc_l = 1'b1;
          nxt   = hit_l ? OVER : ARM;
        end else if (miss_l && miss_r) begin
          nxt = ARM;
        end
      end
      OVER: if (btn_start) begin
        clr = 1'b1;
        nxt = ARM;
      end
      default: nxt = IDLE;
    endcase
  end

  // Serve goes toward the player who just conceded.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      serve_dir <= 1'b0;
      winner    <= 1'b0;
    end else begin
      if (state == PLAY && only_l)      serve_dir <= 1'b0;
      else if (state == PLAY && only_r) serve_dir <= 1'b1;
      if (state == PLAY && nxt == OVER)   winner <= inc_r;
      else if (state == OVER && btn_start) winner <= 1'b0;
    end
  end

  assign timer_start = (state == ARM);
  assign ball_en     = (state == PLAY);
  assign ball_reset  = (state != PLAY);
  assign game_over   = (state == OVER);

endmodule

// File: tb/tb_serve_ctrl.sv
// Bench for serve_ctrl: directed game scenarios plus random traffic, all
// checked cycle by cycle against a rule-level game model.
module tb_serve_ctrl;

  localparam int WIN = 7;
  localparam int P_IDLE = 0, P_ARM = 1, P_WAIT = 2, P_PLAY = 3, P_OVER = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       btn_start = 1'b0, miss_l = 1'b0, miss_r = 1'b0;
  logic       timer_up, timer_start, ball_reset, ball_en, serve_dir, game_over, winner;
  logic [3:0] score_l, score_r;

  int n_vec = 0;
  int n_err = 0;
  int ticks = 120;
  int tcnt  = 0;
  bit lock_en = 1'b0;

  // rule-level game model
  int m_phase = P_IDLE, m_sl = 0, m_sr = 0, m_dir = 0, m_win = 0;

  serve_ctrl dut (
    .clk(clk), .rst_n(rst_n), .btn_start(btn_start), .miss_l(miss_l), .miss_r(miss_r),
    .timer_up(timer_up), .timer_start(timer_start), .ball_reset(ball_reset),
    .ball_en(ball_en), .serve_dir(serve_dir), .score_l(score_l), .score_r(score_r),
    .game_over(game_over), .winner(winner)
  );

  always #5 clk = ~clk;

  // serve timer: loads on timer_start, counts down, flags expiry at zero
  always @(posedge clk) begin
    if (timer_start)   tcnt <= ticks;
    else if (tcnt > 0) tcnt <= tcnt - 1;
  end
  assign timer_up = (tcnt == 0);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase = P_IDLE; m_sl = 0; m_sr = 0; m_dir = 0; m_win = 0;
    end else begin
      case (m_phase)
        P_IDLE: if (btn_start) begin m_sl = 0; m_sr = 0; m_phase = P_ARM; end
        P_ARM:  m_phase = P_WAIT;
        P_WAIT: if (timer_up) m_phase = P_PLAY;
        P_PLAY: begin
          if (miss_l && miss_r) m_phase = P_ARM;
          else if (miss_l) begin
            m_sr = (m_sr + 1 > WIN) ? WIN : m_sr + 1;
            m_dir = 0;
            if (m_sr == WIN) begin m_phase = P_OVER; m_win = 1; end
            else m_phase = P_ARM;
          end else if (miss_r) begin
            m_sl = (m_sl + 1 > WIN) ? WIN : m_sl + 1;
            m_dir = 1;
            if (m_sl == WIN) begin m_phase = P_OVER; m_win = 0; end
            else m_phase = P_ARM;
          end
        end
        P_OVER: if (btn_start) begin m_sl = 0; m_sr = 0; m_win = 0; m_phase = P_ARM; end
        default: m_phase = P_IDLE;
      endcase
    end
  end

  function automatic logic [13:0] model_bus();
    return {m_phase == P_ARM, m_phase != P_PLAY, m_phase == P_PLAY, m_dir[0],
            m_phase == P_OVER, m_win[0], m_sl[3:0], m_sr[3:0]};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  always @(negedge clk)
    if (lock_en)
      check("lock", {timer_start, ball_reset, ball_en, serve_dir, game_over, winner,
                     score_l, score_r}, model_bus());

  task automatic step();
    @(posedge clk);
    #1;
    btn_start = 1'b0;
    miss_l    = 1'b0;
    miss_r    = 1'b0;
  endtask

  task automatic serve(output int n);
    n = 0;
    while (!ball_en && n < 400) begin
      step();
      n++;
    end
    check("serve_to", ball_en, 1);
  endtask

  task automatic point(input bit left_miss);
    int n;
    if (left_miss) miss_l = 1'b1; else miss_r = 1'b1;
    step();
    check("pt_ts", timer_start, 1);
    serve(n);
  endtask

  initial begin
    int n;
    #1 rst_n = 1'b0;
    lock_en = 1'b1;
    step();
    check("rst_sl", score_l, 0);
    check("rst_sr", score_r, 0);
    check("rst_out", {timer_start, ball_en, ball_reset, game_over, winner, serve_dir}, 6'b001000);
    rst_n = 1'b1;

    // start game, ARM then SERVE_WAIT
    repeat (4) step();
    btn_start = 1'b1;
    step();
    check("arm_ts", timer_start, 1);
    check("arm_br", ball_reset, 1);
    step();
    check("wait_ts", timer_start, 0);
    check("wait_br", ball_reset, 1);
    check("wait_be", ball_en, 0);
    miss_l = 1'b1;                       // ignored outside PLAY
    serve(n);
    check("serve_lat", n, 121);
    check("wait_miss", score_r, 0);

    // left player wins 7:0
    for (int i = 1; i <= WIN; i++) begin
      miss_r = 1'b1;
      step();
      check("l_score", score_l, i);
      check("l_dir", serve_dir, 1);
      check("l_ts", timer_start, (i < WIN));
      check("l_go", game_over, (i == WIN));
      if (i < WIN) serve(n);
    end
    check("over_win", winner, 0);
    check("over_be", ball_en, 0);
    miss_l = 1'b1;
    step();
    check("over_miss", {score_l, score_r}, {4'd7, 4'd0});
    btn_start = 1'b1;
    step();
    check("restart_sc", {score_l, score_r}, 8'h00);
    check("restart_win", winner, 0);
    check("restart_ts", timer_start, 1);
    ticks = 3;
    serve(n);

    // simultaneous misses
    point(1'b1);
    miss_l = 1'b1; miss_r = 1'b1;
    step();
    check("both_sc", {score_l, score_r}, {4'd0, 4'd1});
    check("both_dir", serve_dir, 0);
    check("both_ts", timer_start, 1);
    serve(n);

    // reach 3:2, then reset mid-PLAY
    point(1'b0); point(1'b0); point(1'b0); point(1'b1);
    check("pre_rst", {score_l, score_r}, {4'd3, 4'd2});
    rst_n = 1'b0;
    #1;
    check("mid_rst_sc", {score_l, score_r}, 8'h00);
    check("mid_rst_br", ball_reset, 1);
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      check("post_rst_ts", timer_start, 0);
      check("post_rst_br", ball_reset, 1);
    end

    // random traffic, including right-side wins and rare resets
    for (int i = 0; i < 5000; i++) begin
      rst_n     = ($urandom_range(0, 599) != 0);
      btn_start = ($urandom_range(0, 29) == 0);
      miss_l    = ($urandom_range(0, 3) == 0);
      miss_r    = ($urandom_range(0, 4) == 0);
      ticks     = $urandom_range(0, 4);
      step();
    end
    rst_n = 1'b1;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
